// File: rtl/button_debouncer_if.sv
// -----------------------------------------------------------------------------
// button_debouncer_if
//   Groups the signals of one conditioned push-button channel.
//
//   button_in     raw asynchronous button pin, active-high (driven by master)
//   button_level  debounced, registered button state      (driven by slave)
//   repeat_pulse  one-cycle hold-to-repeat strobe          (driven by slave)
//
//   modport master : the side that owns the pin and consumes the clean outputs
//   modport slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface button_debouncer_if;
   logic button_in;
   logic button_level;
   logic repeat_pulse;

   modport master (
      output button_in,
      input  button_level,
      input  repeat_pulse
   );

   modport slave (
      input  button_in,
      output button_level,
      output repeat_pulse
   );
endinterface : button_debouncer_if

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Conditions one raw push-button input. The pin is brought into clk through a
//   two-flop synchronizer, contact bounce is filtered by a stable-time counter
//   in a four-state FSM, and a hold-to-repeat generator emits periodic strobes
//   while the debounced level stays high (auto-fire style).
//
//   Parameters
//     DEBOUNCE_CYCLES  stable cycles required before button_level changes (>= 1)
//     REPEAT_DELAY     cycles from button_level rising to first repeat_pulse;
//                      0 disables repeat generation
//     REPEAT_PERIOD    cycles between subsequent repeat_pulses (>= 1)
//
//   Ports
//     clk    system clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    slave side of button_debouncer_if
//              button_in (in), button_level (out), repeat_pulse (out)
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   button_debouncer_if.slave bus
);

   localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int          CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int          RC_W   = $clog2(RC_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0]  RC_DELAY  = RC_W'(REPEAT_DELAY);
   localparam logic [RC_W-1:0]  RC_PERIOD = RC_W'(REPEAT_PERIOD);
   localparam bit               REPEAT_EN = (REPEAT_DELAY != 0);
   // With a one-cycle debounce the pending states resolve on their first cycle.
   localparam bit               ONE_CYCLE = (DEBOUNCE_CYCLES <= 1);

   typedef enum logic [1:0] {
      LOW,
      RISE_PEND,
      HIGH,
      FALL_PEND
   } state_t;

   state_t           state, state_next;
   logic             s1, s2;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [RC_W-1:0]  rc, rc_next, rc_inc;
   logic             armed, armed_next;
   logic             level, level_next;
   logic             pulse, pulse_next;
   logic             pend_done;
   logic             rc_due;

   // ---------------------------------------------------------------------------
   // State register: synchronizer, FSM, counters and registered outputs.
   // ---------------------------------------------------------------------------
   // NOTE: every flop, synchronizer included, has an async reset so that both
   // outputs drop to 0 the moment rst_n falls, regardless of the clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= LOW;
         cnt   <= '0;
         rc    <= '0;
         armed <= 1'b0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments give every flop the pre-edge value of
         // its source, which is what makes s1 -> s2 a real two-stage shift.
         s1    <= bus.button_in;
         s2    <= s1;
         state <= state_next;
         cnt   <= cnt_next;
         rc    <= rc_next;
         armed <= armed_next;
         level <= level_next;
         pulse <= pulse_next;
      end
   end

   assign pend_done = ONE_CYCLE || (cnt == CNT_LAST);

   // ---------------------------------------------------------------------------
   // Next-state logic: debounce FSM and stable-time counter.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      state_next = state;
      cnt_next   = cnt;
      case (state)
         LOW: begin
            if (s2) begin
               state_next = RISE_PEND;
               cnt_next   = CNT_W'(1);
            end else begin
               cnt_next   = '0;
            end
         end
         RISE_PEND: begin
            if (!s2) begin
               state_next = LOW;
               cnt_next   = '0;
            end else if (pend_done) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s2) begin
               state_next = FALL_PEND;
               cnt_next   = CNT_W'(1);
            end else begin
               cnt_next   = '0;
            end
         end
         FALL_PEND: begin
            if (s2) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else if (pend_done) begin
               state_next = LOW;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = LOW;
            cnt_next   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic: repeat generator and next values of the registered outputs.
   // rc counts HIGH cycles of the current interval; the first interval is
   // REPEAT_DELAY long, later ones REPEAT_PERIOD, selected by armed.
   // ---------------------------------------------------------------------------
   assign rc_inc = rc + RC_W'(1);
   assign rc_due = armed ? (rc_inc == RC_PERIOD) : (rc_inc == RC_DELAY);

   always_comb begin
      rc_next    = rc;
      armed_next = armed;
      pulse_next = 1'b0;
      case (state)
         HIGH: begin
            if (REPEAT_EN) begin
               if (rc_due) begin
                  // On the cycle that leaves for FALL_PEND the due pulse is
                  // dropped, but the schedule still restarts as if it fired.
                  rc_next    = '0;
                  armed_next = 1'b1;
                  pulse_next = s2;
               end else begin
                  rc_next    = rc_inc;
               end
            end
         end
         FALL_PEND: begin
            // Hold rc so a bounce back to HIGH resumes the same interval.
            rc_next    = rc;
            armed_next = armed;
         end
         default: begin
            rc_next    = '0;
            armed_next = 1'b0;
         end
      endcase
      level_next = (state_next == HIGH) || (state_next == FALL_PEND);
   end

   assign bus.button_level = level;
   assign bus.repeat_pulse = pulse;

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Directed bench for button_debouncer with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3. cyc numbers the rising edges; outputs are
//   sampled 1 ns after each edge. Expected repeat pulses are pushed to a queue
//   (as edge numbers) when the stimulus that causes them is driven, and every
//   sampled cycle pops/compares against that queue.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

   localparam int unsigned DB = 4;
   localparam int unsigned RD = 10;
   localparam int unsigned RP = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pulse_q[$];

   int f, e, r, p, e2, g, e3, f2, e4;

   bit bounce_pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   button_debouncer_if bus ();

   button_debouncer #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Advance one edge, then compare repeat_pulse with the scoreboard.
   task automatic step();
      logic exp_p;
      @(posedge clk);
      #1;
      cyc++;
      exp_p = (pulse_q.size() > 0) && (pulse_q[0] == cyc);
      if (exp_p) void'(pulse_q.pop_front());
      check("repeat_pulse", bus.repeat_pulse, exp_p);
   endtask

   task automatic push_pulses(input int first, input int count);
      for (int i = 0; i < count; i++) pulse_q.push_back(first + i * int'(RP));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- Reset held with the button pressed --------------------------------
      bus.button_in = 1'b1;
      rst_n         = 1'b0;
      repeat (3) step();
      check("rst_level", bus.button_level, 1'b0);

      // Release reset mid-cycle; F is the first evaluating edge.
      rst_n = 1'b1;
      f = cyc + 1;
      e = f + 5;
      // Held 30+ cycles: pulses at +10,+13,...,+31 (the last one fires just
      // before the release reaches the FSM).
      push_pulses(e + int'(RD), 8);
      while (cyc < f + 4) step();
      check("rst_rise_early", bus.button_level, 1'b0);
      step();
      check("rst_rise", bus.button_level, 1'b1);
      while (cyc < e + 30) step();
      check("hold_level", bus.button_level, 1'b1);

      // ---- Clean release: level falls 5 edges after the release edge ----------
      bus.button_in = 1'b0;
      r = cyc + 1;
      while (cyc < r + 4) step();
      check("release_early", bus.button_level, 1'b1);
      step();
      check("release_fall", bus.button_level, 1'b0);
      repeat (4) step();

      // ---- Bounce: rises only after the final four-sample stable run ----------
      p = cyc + 1;
      for (int i = 0; i < 9; i++) begin
         bus.button_in = bounce_pat[i];
         step();
         check("bounce_no_toggle", bus.button_level, 1'b0);
      end
      step();
      check("bounce_wait", bus.button_level, 1'b0);
      step();
      check("bounce_rise", bus.button_level, 1'b1);
      e2 = p + 10;

      // ---- Release timed so the first repeat collides with HIGH->FALL_PEND ----
      // No pulse is expected: the due pulse is suppressed, not deferred.
      while (cyc < e2 + 7) step();
      bus.button_in = 1'b0;
      r = cyc + 1;
      while (cyc < r + 4) step();
      check("collide_hold", bus.button_level, 1'b1);
      step();
      check("collide_fall", bus.button_level, 1'b0);
      repeat (4) step();

      // ---- Clean press, then a 2-cycle low glitch seen by the FSM at +11 ------
      bus.button_in = 1'b1;
      g  = cyc + 1;
      e3 = g + 5;
      // First pulse at +10, the next one delayed by the 2 glitch cycles.
      pulse_q.push_back(e3 + 10);
      pulse_q.push_back(e3 + 15);
      pulse_q.push_back(e3 + 18);
      while (cyc < g + 4) step();
      check("press_early", bus.button_level, 1'b0);
      step();
      check("press_rise", bus.button_level, 1'b1);
      while (cyc < e3 + 8) step();
      bus.button_in = 1'b0;
      step();
      step();
      bus.button_in = 1'b1;
      while (cyc < e3 + 18) begin
         step();
         check("glitch_level", bus.button_level, 1'b1);
      end

      // ---- Asynchronous reset while repeat_pulse is high ---------------------
      rst_n = 1'b0;
      #1;
      check("async_rst_level", bus.button_level, 1'b0);
      check("async_rst_pulse", bus.repeat_pulse, 1'b0);
      pulse_q.delete();
      step();
      step();
      rst_n = 1'b1;
      f2 = cyc + 1;
      e4 = f2 + 5;
      push_pulses(e4 + int'(RD), 4);
      while (cyc < f2 + 4) step();
      check("rst2_rise_early", bus.button_level, 1'b0);
      step();
      check("rst2_rise", bus.button_level, 1'b1);
      while (cyc < e4 + 17) step();
      bus.button_in = 1'b0;
      repeat (8) step();
      check("final_low", bus.button_level, 1'b0);
      check("scoreboard_drained", pulse_q.size() == 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_button_debouncer
